// File: rtl/otter_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : otter_mem_arbiter_if
// Purpose  : Bundles the fetch, data and memory-side signals of the OTTER
//            memory arbiter. The slave view is the arbiter itself; the master
//            view is its environment (the fetch/MEM stages and the memory).
// Revision : 1.0 - initial release
// ============================================================================
interface otter_mem_arbiter_if;
    // Instruction fetch channel
    logic        IF_VALID;
    logic [31:0] IF_ADDR;
    logic        IF_READY;
    logic        IF_RSP_VALID;
    logic [31:0] IF_RDATA;
    // Data (MEM stage) channel
    logic        D_VALID;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [1:0]  D_SIZE;
    logic        D_SIGN;
    logic        D_READY;
    logic        D_RSP_VALID;
    logic [31:0] D_RDATA;
    logic        D_ERR;
    // Memory side
    logic        MEM_EN;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_RDATA;

    modport slave (
        input  IF_VALID, IF_ADDR,
        output IF_READY, IF_RSP_VALID, IF_RDATA,
        input  D_VALID, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
        output D_READY, D_RSP_VALID, D_RDATA, D_ERR,
        output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE, MEM_SIGN,
        input  MEM_RDATA
    );

    modport master (
        output IF_VALID, IF_ADDR,
        input  IF_READY, IF_RSP_VALID, IF_RDATA,
        output D_VALID, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
        input  D_READY, D_RSP_VALID, D_RDATA, D_ERR,
        input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE, MEM_SIGN,
        output MEM_RDATA
    );
endinterface
`default_nettype wire

// File: rtl/otter_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : otter_mem_arbiter
// Purpose  : Shares one single-ported memory between instruction fetch and
//            MEM-stage data accesses. Data wins over fetch, but only for
//            MAX_DATA_RUN consecutive grants while a fetch is waiting.
//            Responses return a fixed MEM_LAT cycles after the grant.
// Revision : 1.0 - initial release
// ============================================================================
module otter_mem_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    otter_mem_arbiter_if.slave  bus
);

    localparam int                c_LW        = $clog2(MEM_LAT + 1);
    localparam int                c_RW        = $clog2(MAX_DATA_RUN + 1);
    localparam logic [c_LW-1:0]   c_LAT_LAST  = c_LW'(MEM_LAT - 1);
    localparam logic [c_RW-1:0]   c_RUN_MAX   = c_RW'(MAX_DATA_RUN);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    state_t          r_state, w_state_nxt;
    owner_t          r_owner, w_owner_nxt;
    logic [c_LW-1:0] r_cnt,   w_cnt_nxt;
    logic [c_RW-1:0] r_run,   w_run_nxt;
    logic            r_err,   w_err_nxt;    // outstanding data op was rejected
    logic            r_store, w_store_nxt;  // outstanding data op is a store
    // Last driven bus values, held on cycles without a grant
    logic [31:0]     r_addr,  w_addr_nxt;
    logic [31:0]     r_wdata, w_wdata_nxt;
    logic [1:0]      r_size,  w_size_nxt;
    logic            r_sign,  w_sign_nxt;

    logic            w_resp;
    logic            w_open;
    logic            w_misalign;
    logic            w_gnt_d;
    logic            w_gnt_f;

    // Grant decision, next-state computation and all outputs
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_run_nxt   = r_run;
        w_err_nxt   = r_err;
        w_store_nxt = r_store;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_size_nxt  = r_size;
        w_sign_nxt  = r_sign;

        w_resp     = (r_state == ST_WAIT) && (r_cnt == c_LAT_LAST);
        // RST_N gating keeps READY/MEM_EN low while reset is held
        w_open     = RST_N && ((r_state == ST_IDLE) || w_resp);
        w_misalign = (bus.D_SIZE == 2'b11) ||
                     ((bus.D_SIZE == 2'b01) && bus.D_ADDR[0]) ||
                     ((bus.D_SIZE == 2'b10) && (bus.D_ADDR[1:0] != 2'b00));
        w_gnt_d    = w_open && bus.D_VALID &&
                     ((r_run < c_RUN_MAX) || !bus.IF_VALID);
        w_gnt_f    = w_open && !w_gnt_d && bus.IF_VALID;

        // Run counter only tracks data grants that delay a waiting fetch
        if (!bus.IF_VALID || w_gnt_f) begin
            w_run_nxt = '0;
        end else if (w_gnt_d && (r_run < c_RUN_MAX)) begin
            w_run_nxt = r_run + c_RW'(1);
        end

        if (w_gnt_d) begin
            w_addr_nxt  = bus.D_ADDR;
            w_wdata_nxt = bus.D_WDATA;
            w_size_nxt  = bus.D_SIZE;
            w_sign_nxt  = bus.D_SIGN;
        end else if (w_gnt_f) begin
            w_addr_nxt  = bus.IF_ADDR;
            w_wdata_nxt = '0;
            w_size_nxt  = 2'b10;
            w_sign_nxt  = 1'b0;
        end

        if (w_gnt_d || w_gnt_f) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = '0;
            w_owner_nxt = w_gnt_d ? OWN_DATA : OWN_FETCH;
            w_err_nxt   = w_gnt_d && w_misalign;
            w_store_nxt = w_gnt_d && bus.D_WE;
        end else if (w_resp) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_owner_nxt = OWN_NONE;
            w_err_nxt   = 1'b0;
            w_store_nxt = 1'b0;
        end else if (r_state == ST_WAIT) begin
            w_cnt_nxt   = r_cnt + c_LW'(1);
        end

        bus.IF_READY     = w_gnt_f;
        bus.D_READY      = w_gnt_d;
        // A rejected data access still owns its slot but never touches memory
        bus.MEM_EN       = w_gnt_f || (w_gnt_d && !w_misalign);
        bus.MEM_WE       = w_gnt_d && !w_misalign && bus.D_WE;
        bus.MEM_ADDR     = w_addr_nxt;
        bus.MEM_WDATA    = w_wdata_nxt;
        bus.MEM_SIZE     = w_size_nxt;
        bus.MEM_SIGN     = w_sign_nxt;

        bus.IF_RSP_VALID = w_resp && (r_owner == OWN_FETCH);
        bus.IF_RDATA     = bus.IF_RSP_VALID ? bus.MEM_RDATA : 32'h0;
        bus.D_RSP_VALID  = w_resp && (r_owner == OWN_DATA);
        bus.D_ERR        = bus.D_RSP_VALID && r_err;
        bus.D_RDATA      = (bus.D_RSP_VALID && !r_err && !r_store) ?
                           bus.MEM_RDATA : 32'h0;
    end

    // State register; reset discards any outstanding transaction
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
            r_cnt   <= '0;
            r_run   <= '0;
            r_err   <= 1'b0;
            r_store <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_sign  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_run   <= w_run_nxt;
            r_err   <= w_err_nxt;
            r_store <= w_store_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_size  <= w_size_nxt;
            r_sign  <= w_sign_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_mem_arbiter
// Purpose  : Directed bench for otter_mem_arbiter. A vector table drives the
//            MEM_LAT=1 instance; hand-written sequences cover MEM_LAT=3
//            spacing and asynchronous reset with MEM_LAT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_mem_arbiter;

    logic CLK;
    logic rst_n;
    logic rst2_n;

    int checks;
    int errors;

    otter_mem_arbiter_if bus1();
    otter_mem_arbiter_if bus2();
    otter_mem_arbiter_if bus3();

    otter_mem_arbiter #(.MEM_LAT(1), .MAX_DATA_RUN(4)) u1 (.CLK(CLK), .RST_N(rst_n),  .bus(bus1));
    otter_mem_arbiter #(.MEM_LAT(2), .MAX_DATA_RUN(4)) u2 (.CLK(CLK), .RST_N(rst2_n), .bus(bus2));
    otter_mem_arbiter #(.MEM_LAT(3), .MAX_DATA_RUN(4)) u3 (.CLK(CLK), .RST_N(rst_n),  .bus(bus3));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        if_v;
        logic [31:0] if_a;
        logic        d_v;
        logic        d_we;
        logic [31:0] d_a;
        logic [31:0] d_wd;
        logic [1:0]  d_sz;
        logic        d_sg;
        logic [31:0] mrd;
        logic        e_if_rdy;
        logic        e_if_rsp;
        logic [31:0] e_if_rd;
        logic        e_d_rdy;
        logic        e_d_rsp;
        logic [31:0] e_d_rd;
        logic        e_err;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_ma;
        logic [31:0] e_mwd;
        logic [1:0]  e_msz;
        logic        e_msg;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic if_v, input logic [31:0] if_a, input logic d_v, input logic d_we,
                       input logic [31:0] d_a, input logic [31:0] d_wd, input logic [1:0] d_sz, input logic d_sg,
                       input logic [31:0] mrd, input logic e_if_rdy, input logic e_if_rsp, input logic [31:0] e_if_rd,
                       input logic e_d_rdy, input logic e_d_rsp, input logic [31:0] e_d_rd, input logic e_err,
                       input logic e_en, input logic e_we, input logic [31:0] e_ma, input logic [31:0] e_mwd,
                       input logic [1:0] e_msz, input logic e_msg);
        vec_t v;
        v.if_v = if_v; v.if_a = if_a; v.d_v = d_v; v.d_we = d_we; v.d_a = d_a; v.d_wd = d_wd;
        v.d_sz = d_sz; v.d_sg = d_sg; v.mrd = mrd;
        v.e_if_rdy = e_if_rdy; v.e_if_rsp = e_if_rsp; v.e_if_rd = e_if_rd;
        v.e_d_rdy = e_d_rdy; v.e_d_rsp = e_d_rsp; v.e_d_rd = e_d_rd; v.e_err = e_err;
        v.e_en = e_en; v.e_we = e_we; v.e_ma = e_ma; v.e_mwd = e_mwd; v.e_msz = e_msz; v.e_msg = e_msg;
        vecs.push_back(v);
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d IF_READY", i),     {31'b0, bus1.IF_READY},     {31'b0, v.e_if_rdy});
        chk($sformatf("v%0d IF_RSP_VALID", i), {31'b0, bus1.IF_RSP_VALID}, {31'b0, v.e_if_rsp});
        chk($sformatf("v%0d IF_RDATA", i),     bus1.IF_RDATA,              v.e_if_rd);
        chk($sformatf("v%0d D_READY", i),      {31'b0, bus1.D_READY},      {31'b0, v.e_d_rdy});
        chk($sformatf("v%0d D_RSP_VALID", i),  {31'b0, bus1.D_RSP_VALID},  {31'b0, v.e_d_rsp});
        chk($sformatf("v%0d D_RDATA", i),      bus1.D_RDATA,               v.e_d_rd);
        chk($sformatf("v%0d D_ERR", i),        {31'b0, bus1.D_ERR},        {31'b0, v.e_err});
        chk($sformatf("v%0d MEM_EN", i),       {31'b0, bus1.MEM_EN},       {31'b0, v.e_en});
        chk($sformatf("v%0d MEM_WE", i),       {31'b0, bus1.MEM_WE},       {31'b0, v.e_we});
        chk($sformatf("v%0d MEM_ADDR", i),     bus1.MEM_ADDR,              v.e_ma);
        chk($sformatf("v%0d MEM_WDATA", i),    bus1.MEM_WDATA,             v.e_mwd);
        chk($sformatf("v%0d MEM_SIZE", i),     {30'b0, bus1.MEM_SIZE},     {30'b0, v.e_msz});
        chk($sformatf("v%0d MEM_SIGN", i),     {31'b0, bus1.MEM_SIGN},     {31'b0, v.e_msg});
    endtask

    task automatic idle_bus(input int n);
        if (n == 1) begin
            bus1.IF_VALID = 0; bus1.IF_ADDR = 0; bus1.D_VALID = 0; bus1.D_WE = 0;
            bus1.D_ADDR = 0; bus1.D_WDATA = 0; bus1.D_SIZE = 0; bus1.D_SIGN = 0; bus1.MEM_RDATA = 0;
        end else if (n == 2) begin
            bus2.IF_VALID = 0; bus2.IF_ADDR = 0; bus2.D_VALID = 0; bus2.D_WE = 0;
            bus2.D_ADDR = 0; bus2.D_WDATA = 0; bus2.D_SIZE = 0; bus2.D_SIGN = 0; bus2.MEM_RDATA = 0;
        end else begin
            bus3.IF_VALID = 0; bus3.IF_ADDR = 0; bus3.D_VALID = 0; bus3.D_WE = 0;
            bus3.D_ADDR = 0; bus3.D_WDATA = 0; bus3.D_SIZE = 0; bus3.D_SIGN = 0; bus3.MEM_RDATA = 0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        idle_bus(1); idle_bus(2); idle_bus(3);

        // Fetch stream: one grant per cycle, response one cycle later
        add(1,32'h100, 0,0,0,0,2'd0,0, 32'h13,       1,0,0,          0,0,0,0, 1,0,32'h100,0,2'd2,0);
        add(1,32'h104, 0,0,0,0,2'd0,0, 32'h13,       1,1,32'h13,     0,0,0,0, 1,0,32'h104,0,2'd2,0);
        add(1,32'h108, 0,0,0,0,2'd0,0, 32'h500093,   1,1,32'h500093, 0,0,0,0, 1,0,32'h108,0,2'd2,0);
        add(0,0,       0,0,0,0,2'd0,0, 32'h73,       0,1,32'h73,     0,0,0,0, 0,0,32'h108,0,2'd2,0);
        add(0,0,       0,0,0,0,2'd0,0, 32'hDEAD,     0,0,0,          0,0,0,0, 0,0,32'h108,0,2'd2,0);
        // Both requesting: four data grants, one fetch, then data again
        add(1,32'h200, 1,0,32'h2000,0,2'd2,0, 32'h55, 0,0,0,         1,0,0,0,      1,0,32'h2000,0,2'd2,0);
        add(1,32'h200, 1,0,32'h2000,0,2'd2,0, 32'h55, 0,0,0,         1,1,32'h55,0, 1,0,32'h2000,0,2'd2,0);
        add(1,32'h200, 1,0,32'h2000,0,2'd2,0, 32'h55, 0,0,0,         1,1,32'h55,0, 1,0,32'h2000,0,2'd2,0);
        add(1,32'h200, 1,0,32'h2000,0,2'd2,0, 32'h55, 0,0,0,         1,1,32'h55,0, 1,0,32'h2000,0,2'd2,0);
        add(1,32'h200, 1,0,32'h2000,0,2'd2,0, 32'h55, 1,0,0,         0,1,32'h55,0, 1,0,32'h200,0,2'd2,0);
        add(1,32'h200, 1,0,32'h2000,0,2'd2,0, 32'h55, 0,1,32'h55,    1,0,0,0,      1,0,32'h2000,0,2'd2,0);
        add(0,0,       0,0,0,0,2'd0,0,        32'h55, 0,0,0,         0,1,32'h55,0, 0,0,32'h2000,0,2'd2,0);
        // Aligned word store; response carries no data
        add(0,0, 1,1,32'h3004,32'hCAFEBABE,2'd2,0, 32'h1234, 0,0,0, 1,0,0,0, 1,1,32'h3004,32'hCAFEBABE,2'd2,0);
        add(0,0, 0,1,32'h3004,32'hCAFEBABE,2'd2,0, 32'h1234, 0,0,0, 0,1,0,0, 0,0,32'h3004,32'hCAFEBABE,2'd2,0);
        // Misaligned half, illegal size, misaligned word store, aligned signed byte
        add(0,0, 1,0,32'h3001,0,2'd1,1,           32'hFFFF, 0,0,0, 1,0,0,0, 0,0,32'h3001,0,2'd1,1);
        add(0,0, 1,0,32'h3000,0,2'd3,0,           32'hFFFF, 0,0,0, 1,1,0,1, 0,0,32'h3000,0,2'd3,0);
        add(0,0, 1,1,32'h3002,32'h11223344,2'd2,0, 32'hFFFF, 0,0,0, 1,1,0,1, 0,0,32'h3002,32'h11223344,2'd2,0);
        add(0,0, 1,0,32'h3003,0,2'd0,1,           32'hFFFF, 0,0,0, 1,1,0,1, 1,0,32'h3003,0,2'd0,1);
        // Misaligned fetch passes through; byte load data returns meanwhile
        add(1,32'h102, 0,0,0,0,2'd0,0, 32'hAB,   1,0,0,       0,1,32'hAB,0, 1,0,32'h102,0,2'd2,0);
        add(0,0,       0,0,0,0,2'd0,0, 32'h77,   0,1,32'h77,  0,0,0,0,      0,0,32'h102,0,2'd2,0);

        // Outputs must stay low while reset is held, even with requests up
        @(negedge CLK);
        bus1.IF_VALID = 1; bus1.IF_ADDR = 32'h100; bus1.D_VALID = 1; bus1.D_ADDR = 32'h2000; bus1.D_SIZE = 2'd2;
        #4;
        chk("rst IF_READY", {31'b0, bus1.IF_READY}, 32'h0);
        chk("rst D_READY",  {31'b0, bus1.D_READY},  32'h0);
        chk("rst MEM_EN",   {31'b0, bus1.MEM_EN},   32'h0);
        chk("rst MEM_ADDR", bus1.MEM_ADDR,          32'h0);
        chk("rst D_RSP",    {31'b0, bus1.D_RSP_VALID}, 32'h0);
        @(negedge CLK);
        idle_bus(1);
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        // Table-driven section on the MEM_LAT=1 instance
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            bus1.IF_VALID = vecs[i].if_v; bus1.IF_ADDR = vecs[i].if_a;
            bus1.D_VALID = vecs[i].d_v; bus1.D_WE = vecs[i].d_we; bus1.D_ADDR = vecs[i].d_a;
            bus1.D_WDATA = vecs[i].d_wd; bus1.D_SIZE = vecs[i].d_sz; bus1.D_SIGN = vecs[i].d_sg;
            bus1.MEM_RDATA = vecs[i].mrd;
            #4;
            check_vec(i, vecs[i]);
        end

        // MEM_LAT=3: fetch at T, data waits until the response cycle T+3
        @(negedge CLK);
        bus3.IF_VALID = 1; bus3.IF_ADDR = 32'h500;
        #4;
        chk("L3 T IF_READY", {31'b0, bus3.IF_READY}, 32'h1);
        chk("L3 T MEM_EN",   {31'b0, bus3.MEM_EN},   32'h1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge CLK);
            bus3.IF_VALID = 0; bus3.D_VALID = 1; bus3.D_ADDR = 32'h600; bus3.D_SIZE = 2'd2;
            #4;
            chk($sformatf("L3 T+%0d D_READY", k), {31'b0, bus3.D_READY},      32'h0);
            chk($sformatf("L3 T+%0d MEM_EN", k),  {31'b0, bus3.MEM_EN},       32'h0);
            chk($sformatf("L3 T+%0d IF_RSP", k),  {31'b0, bus3.IF_RSP_VALID}, 32'h0);
        end
        @(negedge CLK);
        bus3.MEM_RDATA = 32'hABCD;
        #4;
        chk("L3 T+3 D_READY",  {31'b0, bus3.D_READY},      32'h1);
        chk("L3 T+3 IF_RSP",   {31'b0, bus3.IF_RSP_VALID}, 32'h1);
        chk("L3 T+3 IF_RDATA", bus3.IF_RDATA,              32'hABCD);
        chk("L3 T+3 MEM_ADDR", bus3.MEM_ADDR,              32'h600);
        for (int k = 4; k <= 5; k++) begin
            @(negedge CLK);
            bus3.D_VALID = 0;
            #4;
            chk($sformatf("L3 T+%0d D_RSP", k), {31'b0, bus3.D_RSP_VALID}, 32'h0);
        end
        @(negedge CLK);
        bus3.MEM_RDATA = 32'h1111;
        #4;
        chk("L3 T+6 D_RSP",   {31'b0, bus3.D_RSP_VALID}, 32'h1);
        chk("L3 T+6 D_RDATA", bus3.D_RDATA,              32'h1111);

        // MEM_LAT=2: reset asserted mid-transaction drops the response
        @(negedge CLK);
        bus2.IF_VALID = 1; bus2.IF_ADDR = 32'h700; bus2.MEM_RDATA = 32'h99;
        #4;
        chk("L2 T IF_READY", {31'b0, bus2.IF_READY}, 32'h1);
        @(negedge CLK);
        bus2.D_VALID = 1; bus2.D_ADDR = 32'h800; bus2.D_SIZE = 2'd2;
        #1 rst2_n = 1'b0;
        #1;
        chk("L2 rst MEM_ADDR", bus2.MEM_ADDR,          32'h0);
        chk("L2 rst MEM_SIZE", {30'b0, bus2.MEM_SIZE}, 32'h0);
        chk("L2 rst D_READY",  {31'b0, bus2.D_READY},  32'h0);
        chk("L2 rst MEM_EN",   {31'b0, bus2.MEM_EN},   32'h0);
        @(negedge CLK);
        #4;
        chk("L2 rst T+2 IF_RSP", {31'b0, bus2.IF_RSP_VALID}, 32'h0);
        chk("L2 rst T+2 IF_RDATA", bus2.IF_RDATA,            32'h0);
        @(negedge CLK);
        idle_bus(2);
        bus2.MEM_RDATA = 32'h99;
        rst2_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #4;
            chk($sformatf("L2 post %0d IF_RSP", k), {31'b0, bus2.IF_RSP_VALID}, 32'h0);
            chk($sformatf("L2 post %0d D_RSP", k),  {31'b0, bus2.D_RSP_VALID},  32'h0);
            @(negedge CLK);
        end
        bus2.IF_VALID = 1; bus2.IF_ADDR = 32'h704;
        #4;
        chk("L2 regrant IF_READY", {31'b0, bus2.IF_READY}, 32'h1);
        chk("L2 regrant MEM_ADDR", bus2.MEM_ADDR,          32'h704);
        @(negedge CLK);
        idle_bus(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Arbitrates one single-ported byte-addressable memory between two requesters: instruction fetch (read-only, word) and data access from the MEM stage (read/write, sized, signed).
- Sits between the pipeline's fetch and MEM stages and the memory module.
- Provides valid/ready handshakes, fixed-latency responses, data-over-fetch priority with an anti-starvation limit, and misaligned-access detection.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from MEM_EN to MEM_RDATA valid; must be ≥1.
- MAX_DATA_RUN, 4, maximum consecutive data grants while fetch is pending; must be ≥1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous reset, active-low.
- IF_VALID  in  1  fetch request.
- IF_ADDR  in  32  fetch address, word-aligned.
- IF_READY  out  1  fetch request accepted this cycle.
- IF_RSP_VALID  out  1  fetch data valid, one-cycle pulse.
- IF_RDATA  out  32  fetched instruction.
- D_VALID  in  1  data request.
- D_WE  in  1  1 = store, 0 = load.
- D_ADDR  in  32  data byte address.
- D_WDATA  in  32  store data.
- D_SIZE  in  2  00 byte, 01 half, 10 word.
- D_SIGN  in  1  1 = zero-extend load (funct3[2]).
- D_READY  out  1  data request accepted this cycle.
- D_RSP_VALID  out  1  data response pulse, for loads and stores.
- D_RDATA  out  32  load data.
- D_ERR  out  1  misaligned or illegal size; qualified by D_RSP_VALID.
- MEM_EN  out  1  memory access strobe.
- MEM_WE  out  1  memory write strobe.
- MEM_ADDR  out  32  memory address.
- MEM_WDATA  out  32  memory write data.
- MEM_SIZE  out  2  memory access size.
- MEM_SIGN  out  1  memory sign control.
- MEM_RDATA  in  32  memory read data.

Behaviour:
- Reset: async assertion of RST_N clears all state.
  - FSM goes to IDLE; latency counter = 0; run counter = 0; owner = none.
  - All outputs = 0 while RST_N is low.
  - Any in-flight response is discarded; no RSP_VALID is issued after reset releases.
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: one transaction outstanding; the counter counts MEM_LAT cycles.
- Grant (combinational) is evaluated in IDLE, and in WAIT during the response cycle (counter == MEM_LAT-1):
  - D_VALID and (run < MAX_DATA_RUN or !IF_VALID) → grant data.
  - Else IF_VALID → grant fetch.
  - Else no grant.
- Only the granted requester sees READY = 1; READY is never high without the matching VALID. Requesters must not make VALID depend on READY.
- Grant cycle T:
  - MEM_ADDR, MEM_WE, MEM_WDATA, MEM_SIZE, MEM_SIGN are driven from the winner.
  - MEM_EN = 1.
  - Fetch is forced to SIZE = 10, SIGN = 0, WE = 0.
- Non-granted cycles: MEM_EN = MEM_WE = 0. The address and data buses hold their last value.
- Response: owner RSP_VALID = 1 for exactly one cycle at T+MEM_LAT, with RDATA = MEM_RDATA. RDATA = 0 when not valid.
  - Stores also pulse D_RSP_VALID; D_RDATA = 0 for stores.
- Throughput: one transaction per MEM_LAT cycles. With MEM_LAT = 1, back-to-back grants occur every cycle.
- Misalignment:
  - Conditions: half with ADDR[0] = 1; word with ADDR[1:0] ≠ 0; D_SIZE = 11.
  - The request is still accepted (D_READY = 1), but MEM_EN = MEM_WE = 0.
  - D_RSP_VALID with D_ERR = 1 and D_RDATA = 0 at T+MEM_LAT, preserving ordering.
  - A misaligned fetch (IF_ADDR[1:0] ≠ 0) is passed through unchanged.
- Run counter (saturating at MAX_DATA_RUN):
  - +1 on each data grant while IF_VALID = 1.
  - Cleared on a fetch grant or on any cycle with IF_VALID = 0.
- Simultaneous response and new grant in the same cycle is legal: the old owner's RSP_VALID and the new READY are both high.
- Counter widths: latency counter is $clog2(MEM_LAT+1) bits; it wraps to 0 on the response cycle.

Test Plan:
- Reset, MEM_LAT=1, IF_VALID=1, IF_ADDR=0x100, MEM_RDATA=0x00000013 → IF_READY=1 and MEM_EN=1 with MEM_ADDR=0x100 in cycle T; IF_RSP_VALID=1 with IF_RDATA=0x13 at T+1; consecutive fetches every cycle.
- IF_VALID and D_VALID both held high, D load of 0x2000, MAX_DATA_RUN=4 → data granted cycles 0-3, fetch granted cycle 4, data granted cycle 5; run counter back to 0 after the fetch grant.
- Store D_WE=1, D_ADDR=0x3004, D_WDATA=0xCAFEBABE, D_SIZE=10 → MEM_EN=1, MEM_WE=1, MEM_WDATA=0xCAFEBABE in cycle T; D_RSP_VALID=1, D_ERR=0, D_RDATA=0 at T+1.
- Load D_SIZE=01, D_ADDR=0x3001 → D_READY=1, MEM_EN=0; at T+1 D_RSP_VALID=1, D_ERR=1, D_RDATA=0. D_SIZE=11 gives the same result.
- MEM_LAT=3, back-to-back fetch then data request → IF_READY at T; D_READY at T+3 together with IF_RSP_VALID; no grant at T+1 or T+2; D_RSP_VALID at T+6.
- MEM_LAT=2, RST_N pulled low at T+1 after a grant → all outputs 0 immediately; after release no IF_RSP_VALID/D_RSP_VALID; FSM in IDLE and a new request is granted on the first valid cycle.
